// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory / MMIO controller.
// Load/store width codes, FSM states and default MMIO map.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] DEF_SEG_ADDR  = 32'h0;
    localparam logic [31:0] DEF_UART_ADDR = 32'h4;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h8;

    typedef enum logic [1:0] {
        IDLE,
        RX_WAIT,
        TX_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Reserved codes fall through to word size.
    function automatic size_t access_size(input logic [2:0] f3);
        case (f3)
            LB, LBU: return SZ_B;
            LH, LHU: return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_bram_be.sv
// True dual-port read-first RAM: port A read-only (fetch), port B with
// per-byte write enables (data).
module bram_be #(
    parameter int unsigned AW = 15
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic [3:0]    b_be,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        for (int unsigned i = 0; i < 4; i++) begin
            if (b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data controller: byte-enable RAM stores, load extension,
// misalignment detection, 7-segment register and stalling UART FIFO access.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       RAM_AW     = 15,
    parameter logic [ADDR_W-1:0] SEG_ADDR   = ADDR_W'(DEF_SEG_ADDR),
    parameter logic [ADDR_W-1:0] UART_ADDR  = ADDR_W'(DEF_UART_ADDR),
    parameter logic [ADDR_W-1:0] STAT_ADDR  = ADDR_W'(DEF_STAT_ADDR),
    parameter int unsigned       RX_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              misalign,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_rdreq,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wrreq,
    output logic [15:0]       seg_io
);

    localparam int unsigned CNT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    size_t           sz;
    logic            is_mmio, is_seg, is_uart, is_stat;
    logic            mis, stall_cond, timeout_hit, accept;
    logic [3:0]      be, ram_be;
    logic [31:0]     wdata_rep, ld_data;
    logic            ld_ram_q, rvalid_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [31:0]     mmio_q, ram_rdata, src, ext;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            unused_inst;

    assign unused_inst = &{1'b0, inst_addr[ADDR_W-1:RAM_AW+2], inst_addr[1:0]};

    assign sz      = access_size(funct3);
    assign is_mmio = (addr[ADDR_W-1:4] == '0);
    assign is_seg  = is_mmio && (addr == SEG_ADDR);
    assign is_uart = is_mmio && (addr == UART_ADDR);
    assign is_stat = is_mmio && (addr == STAT_ADDR);

    always_comb begin
        mis       = 1'b0;
        be        = 4'b1111;
        wdata_rep = wdata;
        case (sz)
            SZ_B: begin
                be        = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                mis       = addr[0];
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: mis = (addr[1:0] != 2'b00);
        endcase
    end

    assign stall_cond  = is_uart && !mis && (we ? tx_full : rx_empty);
    assign timeout_hit = (RX_TIMEOUT != 0) && (cnt == CNT_W'(RX_TIMEOUT - 1));

    // busy drops in the acceptance cycle so the core can advance on that edge.
    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE:    accept = req && !stall_cond;
            RX_WAIT: accept = req && (!rx_empty || timeout_hit);
            TX_WAIT: accept = req && !tx_full;
            default: accept = 1'b0;
        endcase
        if (rst) accept = 1'b0;
    end

    assign busy     = (state != IDLE) ? !accept : (req && stall_cond);
    assign rx_rdreq = accept && is_uart && !we && !mis && !rx_empty;
    assign tx_wrreq = accept && is_uart && we && !mis;
    assign tx_data  = wdata[7:0];
    assign ram_be   = (accept && we && !is_mmio && !mis) ? be : '0;

    // An accepted UART load with the FIFO still empty is the timeout path.
    always_comb begin
        ld_data = '0;
        if (!mis) begin
            if (is_seg)       ld_data = {16'b0, seg_io};
            else if (is_stat) ld_data = {30'b0, tx_full, ~rx_empty};
            else if (is_uart) ld_data = rx_empty ? '1 : {24'b0, rx_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seg_io   <= '0;
            rvalid_q <= 1'b0;
            misalign <= 1'b0;
            ld_ram_q <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            mmio_q   <= '0;
        end else begin
            rvalid_q <= accept && !we;
            misalign <= accept && mis;
            if (accept) begin
                f3_q     <= funct3;
                off_q    <= addr[1:0];
                ld_ram_q <= !is_mmio && !mis;
                mmio_q   <= ld_data;
            end
            if (accept && we && is_seg && !mis) seg_io <= wdata[15:0];
            case (state)
                IDLE: begin
                    if (req && stall_cond) begin
                        state <= we ? TX_WAIT : RX_WAIT;
                        cnt   <= '0;
                    end
                end
                RX_WAIT: begin
                    if (accept) state <= IDLE;
                    else        cnt   <= cnt + CNT_W'(1);
                end
                TX_WAIT: if (accept) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    bram_be #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .a_addr  (inst_addr[RAM_AW+1:2]),
        .a_rdata (inst_rdata),
        .b_addr  (addr[RAM_AW+1:2]),
        .b_be    (ram_be),
        .b_wdata (wdata_rep),
        .b_rdata (ram_rdata)
    );

    assign src      = ld_ram_q ? ram_rdata : mmio_q;
    assign byte_sel = src[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? src[31:16] : src[15:0];

    always_comb begin
        ext = src;
        case (f3_q)
            LB:      ext = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ext = {24'b0, byte_sel};
            LH:      ext = {{16{half_sel[15]}}, half_sel};
            LHU:     ext = {16'b0, half_sel};
            default: ext = src;
        endcase
    end

    assign rvalid = rvalid_q;
    assign rdata  = rvalid_q ? ext : '0;

endmodule
